// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, payload layout and stall counter limit for pipe_stage_reg.
package pipe_pkg;
  localparam int INSTR_W_D = 8;
  localparam int DATA_W_D = 8;
  localparam int RD_W_D = 2;
  typedef struct packed {
    logic [INSTR_W_D-1:0] instr;
    logic [DATA_W_D-1:0] data;
    logic [RD_W_D-1:0] rd;
    logic regwrite;
  } payload_t;
  function automatic logic [31:0] STALL_CNT_MAX(input int w);
    return 32'((33'd1 << w) - 33'd1);
  endfunction
endpackage

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: one-entry payload+valid holder; clear beats load beats unload.
module pipe_skid_slot #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic         i_unload,
  input  logic [W-1:0] i_d,
  output logic         o_valid,
  output logic [W-1:0] o_q
);
  logic         r_valid;
  logic [W-1:0] r_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_valid <= 1'b0;
      r_q <= '0;
    end else begin
      r_valid <= i_clr ? 1'b0 : i_load ? 1'b1 : i_unload ? 1'b0 : r_valid;
      if (i_load && !i_clr) r_q <= i_d;
    end
  assign o_valid = r_valid;
  assign o_q = r_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush, forwarding tap and stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry and register in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int RD_W = RD_W_D,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [RD_W-1:0]    in_rd,
  input  logic               in_regwrite,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [DATA_W-1:0]  out_data,
  output logic [RD_W-1:0]    out_rd,
  output logic               out_regwrite,
  output logic               fwd_valid,
  output logic [CNT_W-1:0]   stall_cnt
);
  localparam int PW = INSTR_W + DATA_W + RD_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_CNT_MAX(CNT_W));
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0] rd;
    logic regwrite;
  } pay_t;
  pay_t             w_in, w_main, w_main_d;
  logic             w_main_v, w_acc, w_main_load;
  logic [CNT_W-1:0] r_cnt;
  assign w_in = {in_instr, in_data, in_rd, in_regwrite};
  assign w_acc = in_valid && in_ready;
`ifdef PIPE_STAGE_SKID_EN
  logic w_skid_v, w_main_adv;
  pay_t w_skid;
  assign in_ready = !w_skid_v && !flush;
  assign w_main_adv = !w_main_v || out_ready;
  // skid always drains first so ordering stays FIFO
  assign w_main_load = w_main_adv && (w_skid_v || w_acc);
  assign w_main_d = w_skid_v ? w_skid : w_in;
  pipe_skid_slot #(.W(PW)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (flush),
    .i_load   (w_acc && w_main_v && !out_ready),
    .i_unload (w_main_adv),
    .i_d      (w_in),
    .o_valid  (w_skid_v),
    .o_q      (w_skid)
  );
`else
  assign in_ready = !flush && (!w_main_v || out_ready);
  assign w_main_load = w_acc;
  assign w_main_d = w_in;
`endif
  pipe_skid_slot #(.W(PW)) u_main (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (flush),
    .i_load   (w_main_load),
    .i_unload (out_ready),
    .i_d      (w_main_d),
    .o_valid  (w_main_v),
    .o_q      (w_main)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (w_main_v && !out_ready && r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
  assign out_valid = w_main_v;
  assign out_instr = w_main.instr;
  assign out_data = w_main.data;
  assign out_rd = w_main.rd;
  assign out_regwrite = w_main.regwrite && w_main_v;
  assign fwd_valid = out_regwrite;
  assign stall_cnt = r_cnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg (either PIPE_STAGE_SKID_EN build).
module tb_pipe_stage_reg;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_instr = '0;
  logic [7:0] in_data = '0;
  logic [1:0] in_rd = '0;
  logic       in_regwrite = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_instr;
  logic [7:0] out_data;
  logic [1:0] out_rd;
  logic       out_regwrite;
  logic       fwd_valid;
  logic [7:0] stall_cnt;
  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_reg dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_data      (in_data),
    .in_rd        (in_rd),
    .in_regwrite  (in_regwrite),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_data     (out_data),
    .out_rd       (out_rd),
    .out_regwrite (out_regwrite),
    .fwd_valid    (fwd_valid),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_regwrite", 32'(out_regwrite), 32'd0);
    check("rst_fwd", 32'(fwd_valid), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    reset = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_instr = 8'hA5; in_data = 8'h3C; in_rd = 2'd2; in_regwrite = 1'b1; out_ready = 1'b1;
    tick();
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_instr", 32'(out_instr), 32'hA5);
    check("first_data", 32'(out_data), 32'h3C);
    check("first_rd", 32'(out_rd), 32'd2);
    check("first_fwd", 32'(fwd_valid), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      in_data = 8'(k);
      #1;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data", 32'(out_data), 32'(k));
    end
    out_ready = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    in_data = 8'h55;
    #1;
    check("stall_in_ready_skid", 32'(in_ready), 32'd1);
`else
    in_valid = 1'b0;
    #1;
    check("stall_in_ready", 32'(in_ready), 32'd0);
`endif
    tick();
    in_valid = 1'b0;
    check("stall_in_ready_full", 32'(in_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("stall_hold_data", 32'(out_data), 32'd4);
      tick();
    end
    check("stall_hold_valid", 32'(out_valid), 32'd1);
    check("stall_hold_data_end", 32'(out_data), 32'd4);
    check("stall_cnt5", 32'(stall_cnt), 32'd5);
    out_ready = 1'b1;
    tick();
`ifdef PIPE_STAGE_SKID_EN
    check("skid_drain_valid", 32'(out_valid), 32'd1);
    check("skid_drain_data", 32'(out_data), 32'h55);
    tick();
`endif
    check("drained_valid", 32'(out_valid), 32'd0);
    check("bubble_regwrite", 32'(out_regwrite), 32'd0);
    check("bubble_fwd", 32'(fwd_valid), 32'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    tick();
    check("pre_flush_data", 32'(out_data), 32'h77);
    in_data = 8'h99; flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_regwrite", 32'(out_regwrite), 32'd0);
    check("flush_fwd", 32'(fwd_valid), 32'd0);
    check("flush_keeps_cnt", 32'(stall_cnt), 32'd6);
    tick();
    check("dropped_never_seen", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 300; k++) tick();
    check("sat_cnt", 32'(stall_cnt), 32'd255);
    check("sat_data", 32'(out_data), 32'h11);
`ifdef PIPE_STAGE_SKID_EN
    in_valid = 1'b1; in_data = 8'h22;
    tick();
    in_valid = 1'b0;
    check("skid_full_in_ready", 32'(in_ready), 32'd0);
`endif
    #1 reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_cnt", 32'(stall_cnt), 32'd0);
    check("async_rst_data", 32'(out_data), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    #1 reset = 1'b1;
    in_valid = 1'b1; in_data = 8'h33; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_data", 32'(out_data), 32'h33);
    tick();
    check("post_rst_empty", 32'(out_valid), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register; next generation of the fixed 8-bit EX→WB latch.
- Carries instruction, ALU result, destination register and RegWrite between any two pipeline stages.
- Adds a valid/ready handshake (stall), synchronous flush (bubble insertion), a forwarding tap and a saturating stall counter.
- Instantiated at ID/EX, EX/WB and future stage boundaries.

Parameters:
- INSTR_W, 8, instruction field width
- DATA_W, 8, ALU result width
- RD_W, 2, destination register address width
- CNT_W, 8, stall counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low
- flush  in  1  synchronous; kills all held entries this cycle
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept payload
- in_instr  in  INSTR_W  instruction
- in_data  in  DATA_W  ALU result
- in_rd  in  RD_W  destination register
- in_regwrite  in  1  write-back enable
- out_valid  out  1  downstream payload valid
- out_ready  in  1  downstream accepts payload
- out_instr  out  INSTR_W  held instruction
- out_data  out  DATA_W  held result
- out_rd  out  RD_W  held destination
- out_regwrite  out  1  held RegWrite AND out_valid
- fwd_valid  out  1  out_valid AND out_regwrite, for the hazard unit
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset is asynchronous and active-low; clock is clk.
- While reset=0:
  - out_valid=0; out_instr, out_data, out_rd, out_regwrite, fwd_valid=0.
  - stall_cnt=0; skid entry empty.
  - in_ready=1 once reset is released.
- Reset asserted mid-transfer discards all entries immediately. There is no partial state.
- Transfer rules:
  - Input accepted when in_valid && in_ready at the clock edge.
  - Output consumed when out_valid && out_ready at the clock edge.
- Latency: one cycle from input accept to out_valid.
- Throughput: one transfer per cycle while out_ready=1.
- Main register, no skid:
  - in_ready = !out_valid || out_ready. This is a combinational path from out_ready.
  - Accept with simultaneous consume: main loads new payload; out_valid stays 1.
  - Consume without accept: out_valid→0; payload fields keep old values (don't-care).
  - Stall (out_valid && !out_ready): all out_* held stable and bit-exact.
- Flush:
  - Flush has priority over everything else.
  - Next cycle out_valid=0, and the skid entry is cleared.
  - in_ready=0 during the flush cycle; any in_valid that cycle is dropped.
  - Flush with out_ready=1 the same cycle: the consume still counts downstream. Flush only affects the next state.
- out_regwrite and fwd_valid are forced 0 whenever out_valid=0, so a bubble can never write the register file.
- stall_cnt:
  - Increments each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W−1 with no wrap.
  - Cleared only by reset; flush does not clear it.
- in_ready and out_valid never depend combinationally on in_valid.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Defined: adds a second (skid) entry, making in_ready registered.
  - in_ready = !skid_valid.
  - If main is stalled and an input is accepted, the input goes to skid.
  - When out_ready rises, skid moves to main the next cycle. Ordering is strictly FIFO.
  - Both entries full: in_ready=0.
  - Full throughput is preserved, and there is no out_ready→in_ready combinational path.
- Undefined: single entry, combinational in_ready as described above. The skid logic is absent from the netlist.

Decomposition:
- Package pipe_pkg holds:
  - default width constants (INSTR_W_D=8, DATA_W_D=8, RD_W_D=2);
  - a packed payload typedef {instr, data, rd, regwrite};
  - a STALL_CNT_MAX helper function.
- One natural sub-module: pipe_skid_slot. It is a one-entry payload+valid holder, used for main and, when enabled, skid.

Test Plan:
- Reset, then in_valid=1, in_instr=8'hA5, in_data=8'h3C, in_rd=2, in_regwrite=1, out_ready=1 → next cycle out_valid=1, out_data=8'h3C, out_rd=2, fwd_valid=1.
- Stream 4 beats (data 1,2,3,4) with out_ready=1 → outputs 1,2,3,4 on consecutive cycles; in_ready stays 1.
- Hold out_ready=0 for 5 cycles with a valid entry → outputs stable; stall_cnt=5; with PIPE_STAGE_SKID_EN one extra beat is accepted, then in_ready=0.
- Assert flush with out_valid=1 and in_valid=1 → next cycle out_valid=0, out_regwrite=0, fwd_valid=0; the dropped beat never appears.
- Force 300 stall cycles with CNT_W=8 → stall_cnt sticks at 255.
- Drop reset to 0 mid-stall with skid full → out_valid=0 and stall_cnt=0 immediately (asynchronous); after release, the first accepted beat appears after one cycle.
